dcache_assoc: RTL and testbench
===============================

DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, CPU word width.
REQ-003 SHALL have parameter LINE_W, default 256, cache line and memory beat width.
REQ-004 SHALL have parameter SETS, default 16, number of sets; must be a power of 2.
REQ-005 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2 and 4.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port p1_addr_i, input, ADDR_W, CPU byte address.
REQ-010 SHALL have port p1_data_i, input, DATA_W, CPU store data.
REQ-011 SHALL have port p1_MemRead_i, input, 1, load request.
REQ-012 SHALL have port p1_MemWrite_i, input, 1, store request.
REQ-013 SHALL have port p1_data_o, output, DATA_W, load data.
REQ-014 SHALL have port p1_stall_o, output, 1, CPU pipeline stall.
REQ-015 SHALL have port flush_i, input, 1, pulse that requests write-back of all dirty lines.
REQ-016 SHALL have port flush_busy_o, output, 1, high while a flush is in progress.
REQ-017 SHALL have ports mem_data_i (input, LINE_W) and mem_ack_i (input, 1): refill data and completion pulse.
REQ-018 SHALL have ports mem_data_o (output, LINE_W), mem_addr_o (output, ADDR_W), mem_enable_o (output, 1) and mem_write_o (output, 1): the memory request.

Function
REQ-019 SHALL split the address into three fields:
- offset: log2(LINE_W/8) bits
- index: log2(SETS) bits
- tag: the remaining bits
The word is selected by the offset, dropping its low log2(DATA_W/8) bits.
REQ-020 SHALL be write-back and write-allocate; each line SHALL hold valid, dirty, tag and data.
REQ-021 SHALL detect a hit combinationally in the request cycle; on a hit p1_stall_o=0, and p1_data_o returns the word in the same cycle.
REQ-022 SHALL, on a store hit, write the word and set dirty at the next clock edge.
REQ-023 SHALL treat p1_MemRead_i and p1_MemWrite_i both high as a store.
REQ-024 SHALL hold p1_stall_o=1 combinationally from the cycle a miss is detected until the request completes as a hit.
REQ-025 SHALL use the FSM IDLE -> (miss) -> VICTIM -> (victim dirty) WRITEBACK -> ALLOCATE -> IDLE; a clean or invalid victim goes VICTIM -> ALLOCATE.
REQ-026 SHALL choose the victim as follows: the lowest-numbered invalid way if one exists, otherwise the way named by a per-set round-robin pointer; the pointer advances by one, mod WAYS, on each allocation into that set.
REQ-027 SHALL, in WRITEBACK, drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 0} and mem_data_o=victim line, holding all of them until mem_ack_i.
REQ-028 SHALL, in ALLOCATE, drive mem_enable_o=1, mem_write_o=0 and the line-aligned miss address, holding them until mem_ack_i.
REQ-029 SHALL, on mem_ack_i in ALLOCATE, write mem_data_i, the tag and valid=1, dirty=0, and return to IDLE, where the request hits.
REQ-030 SHALL ignore mem_ack_i outside WRITEBACK/ALLOCATE; memory latency is unbounded.
REQ-031 SHALL, on flush_i in IDLE with no miss pending, enter FLUSH and set flush_busy_o=1.
REQ-032 SHALL, in FLUSH, scan set 0..SETS-1 and within each set way 0..WAYS-1; each dirty line is written back (protocol as REQ-027) and then marked clean.
REQ-033 SHALL, in FLUSH, leave lines valid, hold p1_stall_o=1 when a request is present, and clear flush_busy_o in the cycle after the last way is scanned.
REQ-034 SHALL, if flush_i arrives while busy with a miss, latch it and start the flush after returning to IDLE.

Reset
REQ-035 SHALL, on rst_i=0 at any time (including mid-transfer), immediately:
- clear all valid, dirty and round-robin state
- set FSM=IDLE and drop the pending flush
- drive mem_enable_o=0, mem_write_o=0, flush_busy_o=0, p1_stall_o=0, p1_data_o=0, mem_addr_o=0, mem_data_o=0
REQ-036 SHALL leave data and tag arrays uncleared by reset.

Structure
REQ-037 SHALL place the FSM state enum and the field-width calculation functions in package dcache_pkg.
REQ-038 SHALL instantiate sub-module dcache_way (tag/valid/dirty/data storage for one way, with hit compare) WAYS times.

Verification
REQ-039 Reset, then read 0x0000_0400 -> stall=1; read request to 0x400; ack after 10 cycles with word0=0xDEAD_BEEF -> stall=0 and p1_data_o=0xDEAD_BEEF.
REQ-040 Repeat the read of 0x404 -> hit in the request cycle, stall=0, and mem_enable_o stays 0.
REQ-041 Store 0x1234_5678 to 0x400, then read 0x600 and 0x800 (same set, WAYS=2) -> write-back to 0x400 carries 0x1234_5678 before the refill of 0x800.
REQ-042 Dirty lines at sets 1 and 5, then pulse flush_i -> exactly two write-backs, set 1 first; flush_busy_o falls afterwards and subsequent reads of those lines still hit.
REQ-043 Assert rst_i=0 three cycles into a refill -> all outputs are 0 immediately; the next read of the same address misses.
REQ-044 Assert p1_MemRead_i and p1_MemWrite_i together on a hit -> the word is stored and dirty is set.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VICTIM    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_FLUSH     = 3'd4,
    S_FLUSH_WB  = 3'd5
  } state_e;

  // Byte offset within a line.
  function automatic int off_width(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Set index.
  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  // Whatever address bits remain above index and offset.
  function automatic int tag_width(input int addr_w, input int line_w, input int sets);
    return addr_w - off_width(line_w) - idx_width(sets);
  endfunction

  // Byte-within-word bits that are dropped when selecting a word.
  function automatic int byte_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word select within a line (line must be wider than a word).
  function automatic int wsel_width(input int line_w, input int data_w);
    return $clog2(line_w / data_w);
  endfunction

  // Way number; a direct-mapped cache still carries a 1-bit way field.
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty/tag/data storage for every set plus the tag compare.
module dcache_way
  import dcache_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int LINE_W = 256,
  parameter  int SETS   = 16,
  localparam int IDX_W  = idx_width(SETS),
  localparam int TAG_W  = tag_width(ADDR_W, LINE_W, SETS),
  localparam int WSEL_W = wsel_width(LINE_W, DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  cmp_tag,
  output logic              hit,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line,
  input  logic              wr_en,
  input  logic [WSEL_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_word,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              clean_en
);

  logic [SETS-1:0]   valid_bits;
  logic [SETS-1:0]   dirty_bits;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  assign valid = valid_bits[idx];
  assign dirty = dirty_bits[idx];
  assign tag   = tag_mem[idx];
  assign line  = data_mem[idx];
  assign hit   = valid && (tag == cmp_tag);

  // Line state: a refill makes the line valid and clean, a store dirties it, a flush cleans it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill_en) begin
      valid_bits[idx] <= 1'b1;
      dirty_bits[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_bits[idx] <= 1'b1;
    end else if (clean_en) begin
      dirty_bits[idx] <= 1'b0;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= fill_tag;
      data_mem[idx] <= fill_line;
    end else if (wr_en) begin
      data_mem[idx][wr_sel*DATA_W +: DATA_W] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate set-associative data cache with round-robin
// replacement and a whole-cache flush that writes back every dirty line.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int OFF_W  = off_width(LINE_W);
  localparam int IDX_W  = idx_width(SETS);
  localparam int TAG_W  = tag_width(ADDR_W, LINE_W, SETS);
  localparam int BYTE_W = byte_width(DATA_W);
  localparam int WSEL_W = wsel_width(LINE_W, DATA_W);
  localparam int WAY_W  = way_width(WAYS);

  // Request address fields
  logic              req;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_sel;
  logic              unused_byte_bits;

  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
  assign req_sel          = p1_addr_i[BYTE_W +: WSEL_W];
  assign unused_byte_bits = ^p1_addr_i[BYTE_W-1:0];

  // Control state
  state_e           state;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [WAY_W-1:0] victim_way;
  logic [IDX_W-1:0] scan_set;
  logic [WAY_W-1:0] scan_way;
  logic             flush_pend;
  logic [WAY_W-1:0] rr [SETS];

  // Per-way views of the currently indexed set
  logic [IDX_W-1:0]  way_idx;
  logic [WAYS-1:0]   way_hit;
  logic [WAYS-1:0]   way_valid;
  logic [WAYS-1:0]   way_dirty;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];

  logic              hit_any;
  logic [LINE_W-1:0] hit_line;
  logic [DATA_W-1:0] hit_word;
  logic              store_hit;
  logic              miss;
  logic              fill_go;
  logic              clean_go;
  logic [WAY_W-1:0]  victim_sel;
  logic              victim_found;
  logic              scan_last;

  // All ways share one index: the live request when idle, the flush cursor
  // while flushing, and the latched miss set while servicing a miss.
  always_comb begin
    way_idx = miss_idx;
    case (state)
      S_IDLE:              way_idx = req_idx;
      S_FLUSH, S_FLUSH_WB: way_idx = scan_set;
      default:             way_idx = miss_idx;
    endcase
  end

  assign hit_any   = (state == S_IDLE) && (|way_hit);
  assign store_hit = hit_any && p1_MemWrite_i;
  assign miss      = (state == S_IDLE) && req && !(|way_hit);
  assign fill_go   = (state == S_ALLOCATE) && mem_ack_i;
  assign clean_go  = (state == S_FLUSH_WB) && mem_ack_i;
  assign scan_last = (scan_set == IDX_W'(SETS - 1)) && (scan_way == WAY_W'(WAYS - 1));

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LINE_W (LINE_W),
      .SETS   (SETS)
    ) u_way (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .idx       (way_idx),
      .cmp_tag   (req_tag),
      .hit       (way_hit[g]),
      .valid     (way_valid[g]),
      .dirty     (way_dirty[g]),
      .tag       (way_tag[g]),
      .line      (way_line[g]),
      .wr_en     (store_hit && way_hit[g]),
      .wr_sel    (req_sel),
      .wr_word   (p1_data_i),
      .fill_en   (fill_go && (victim_way == WAY_W'(g))),
      .fill_tag  (miss_tag),
      .fill_line (mem_data_i),
      .clean_en  (clean_go && (scan_way == WAY_W'(g)))
    );
  end

  // Pick the hitting way's line and extract the addressed word.
  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_line = way_line[w];
    end
    hit_word = hit_line[req_sel*DATA_W +: DATA_W];
  end

  // Victim: lowest-numbered invalid way, else the set's round-robin pointer.
  always_comb begin
    victim_sel   = rr[miss_idx];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !way_valid[w]) begin
        victim_sel   = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  // Miss/flush controller; a flush request seen mid-miss waits in flush_pend.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      miss_tag   <= '0;
      miss_idx   <= '0;
      victim_way <= '0;
      scan_set   <= '0;
      scan_way   <= '0;
      flush_pend <= 1'b0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            state    <= S_VICTIM;
            if (flush_i) flush_pend <= 1'b1;
          end else if (flush_i || flush_pend) begin
            flush_pend <= 1'b0;
            scan_set   <= '0;
            scan_way   <= '0;
            state      <= S_FLUSH;
          end
        end
        S_VICTIM: begin
          if (flush_i) flush_pend <= 1'b1;
          victim_way <= victim_sel;
          state      <= (way_valid[victim_sel] && way_dirty[victim_sel]) ? S_WRITEBACK : S_ALLOCATE;
        end
        S_WRITEBACK: begin
          if (flush_i) flush_pend <= 1'b1;
          if (mem_ack_i) state <= S_ALLOCATE;
        end
        S_ALLOCATE: begin
          if (flush_i) flush_pend <= 1'b1;
          if (mem_ack_i) begin
            rr[miss_idx] <= (rr[miss_idx] == WAY_W'(WAYS - 1)) ? '0 : rr[miss_idx] + 1'b1;
            state        <= S_IDLE;
          end
        end
        S_FLUSH, S_FLUSH_WB: begin
          if ((state == S_FLUSH) && way_valid[scan_way] && way_dirty[scan_way]) begin
            state <= S_FLUSH_WB;
          end else if ((state == S_FLUSH) || mem_ack_i) begin
            if (scan_last) begin
              state <= S_IDLE;
            end else begin
              state <= S_FLUSH;
              if (scan_way == WAY_W'(WAYS - 1)) begin
                scan_way <= '0;
                scan_set <= scan_set + 1'b1;
              end else begin
                scan_way <= scan_way + 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from state; everything is forced low while reset is held.
  always_comb begin
    p1_stall_o   = 1'b0;
    p1_data_o    = '0;
    flush_busy_o = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    if (rst_i) begin
      p1_stall_o = req && !hit_any;
      p1_data_o  = hit_any ? hit_word : '0;
      case (state)
        S_WRITEBACK: begin
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {way_tag[victim_way], miss_idx, {OFF_W{1'b0}}};
          mem_data_o   = way_line[victim_way];
        end
        S_ALLOCATE: begin
          mem_enable_o = 1'b1;
          mem_addr_o   = {miss_tag, miss_idx, {OFF_W{1'b0}}};
        end
        S_FLUSH: begin
          flush_busy_o = 1'b1;
        end
        S_FLUSH_WB: begin
          flush_busy_o = 1'b1;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {way_tag[scan_way], scan_set, {OFF_W{1'b0}}};
          mem_data_o   = way_line[scan_way];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc with expected-response queues for the CPU and memory sides.
module tb_dcache_assoc;

  localparam int LW = 256;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] fill;
    logic        noack;
  } mem_t;

  logic          clk;
  logic          rst_n;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          rd;
  logic          wr;
  logic [31:0]   rdata;
  logic          stall;
  logic          flush;
  logic          busy;
  logic [LW-1:0] mem_rdata;
  logic          mem_ack;
  logic [LW-1:0] mem_wdata;
  logic [31:0]   mem_addr;
  logic          mem_en;
  logic          mem_we;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wb_count = 0;
  mem_t        mem_q[$];
  logic [31:0] cpu_q[$];

  dcache_assoc dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .p1_addr_i     (addr),
    .p1_data_i     (wdata),
    .p1_MemRead_i  (rd),
    .p1_MemWrite_i (wr),
    .p1_data_o     (rdata),
    .p1_stall_o    (stall),
    .flush_i       (flush),
    .flush_busy_o  (busy),
    .mem_data_i    (mem_rdata),
    .mem_ack_i     (mem_ack),
    .mem_data_o    (mem_wdata),
    .mem_addr_o    (mem_addr),
    .mem_enable_o  (mem_en),
    .mem_write_o   (mem_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  function automatic mem_t mk(input logic w, input logic [31:0] a, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] f, input logic na);
    mem_t m;
    m.wr = w; m.addr = a; m.w0 = d0; m.w1 = d1; m.fill = f; m.noack = na;
    return m;
  endfunction

  function automatic logic [LW-1:0] fill_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = base + k;
    return l;
  endfunction

  // CPU-side monitor: every completed load is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rd && !wr && !stall) begin
      if (cpu_q.size() == 0) fail_now("load_unexpected");
      else check("load_data", rdata, cpu_q.pop_front());
    end
  end

  // Memory-side monitor and responder: checks each new request, acks after 10 cycles.
  bit   active = 0;
  bit   acking = 0;
  int   lat    = 0;
  mem_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      active  = 0;
      acking  = 0;
      mem_ack = 0;
    end else begin
      if (acking) begin
        mem_ack = 0;
        acking  = 0;
        active  = 0;
      end
      if (mem_en && !active) begin
        active = 1;
        lat    = 10;
        if (mem_we) wb_count++;
        if (mem_q.size() == 0) begin
          fail_now("mem_unexpected");
          cur = mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        end else begin
          cur = mem_q.pop_front();
          check("mem_write", {31'b0, mem_we}, {31'b0, cur.wr});
          check("mem_addr", mem_addr, cur.addr);
          if (cur.wr) begin
            check("wb_word0", mem_wdata[31:0], cur.w0);
            check("wb_word1", mem_wdata[63:32], cur.w1);
          end
        end
      end else if (active && !acking && !cur.noack) begin
        lat--;
        if (lat == 0) begin
          mem_rdata = fill_line(cur.fill);
          mem_ack   = 1;
          acking    = 1;
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (stall && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (stall) fail_now(name);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input bit exp_hit);
    cpu_q.push_back(exp);
    @(posedge clk); #1;
    addr = a; rd = 1; wr = 0;
    @(negedge clk);
    check("first_cycle_stall", {31'b0, stall}, {31'b0, !exp_hit});
    if (exp_hit) check("hit_no_mem", {31'b0, mem_en}, 32'd0);
    wait_ready("read_timeout");
    @(posedge clk); #1;
    rd = 0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit with_read);
    @(posedge clk); #1;
    addr = a; wdata = d; wr = 1; rd = with_read;
    @(negedge clk);
    check("store_hit_stall", {31'b0, stall}, 32'd0);
    wait_ready("store_timeout");
    @(posedge clk); #1;
    wr = 0; rd = 0;
  endtask

  task automatic do_flush(input int exp_wb);
    int n = 0;
    wb_count = 0;
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("flush_busy_rise", {31'b0, busy}, 32'd1);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("flush_timeout");
    check("flush_wb_count", wb_count, exp_wb);
  endtask

  initial begin
    int n;
    clk = 0; rst_n = 0; addr = 32'h400; wdata = 0; rd = 1; wr = 0;
    flush = 0; mem_rdata = '0; mem_ack = 0;
    #2;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rd = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;

    // Cold miss, then hit on the neighbouring word
    mem_q.push_back(mk(1'b0, 32'h400, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0));
    do_read(32'h400, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h404, 32'hDEAD_BEF0, 1'b1);

    // Dirty line in way 0 of set 0 is evicted by the third tag
    do_store(32'h400, 32'h1234_5678, 1'b0);
    mem_q.push_back(mk(1'b0, 32'h600, 32'h0, 32'h0, 32'h6000_0000, 1'b0));
    do_read(32'h600, 32'h6000_0000, 1'b0);
    mem_q.push_back(mk(1'b1, 32'h400, 32'h1234_5678, 32'hDEAD_BEF0, 32'h0, 1'b0));
    mem_q.push_back(mk(1'b0, 32'h800, 32'h0, 32'h0, 32'h8000_0000, 1'b0));
    do_read(32'h800, 32'h8000_0000, 1'b0);
    do_read(32'h604, 32'h6000_0001, 1'b1);

    // Dirty lines in sets 1 and 5, then flush
    mem_q.push_back(mk(1'b0, 32'h020, 32'h0, 32'h0, 32'h0200_0000, 1'b0));
    do_read(32'h020, 32'h0200_0000, 1'b0);
    do_store(32'h020, 32'hAAAA_0001, 1'b0);
    mem_q.push_back(mk(1'b0, 32'h0A0, 32'h0, 32'h0, 32'h0A00_0000, 1'b0));
    do_read(32'h0A0, 32'h0A00_0000, 1'b0);
    do_store(32'h0A4, 32'hBBBB_0005, 1'b0);
    mem_q.push_back(mk(1'b1, 32'h020, 32'hAAAA_0001, 32'h0200_0001, 32'h0, 1'b0));
    mem_q.push_back(mk(1'b1, 32'h0A0, 32'h0A00_0000, 32'hBBBB_0005, 32'h0, 1'b0));
    do_flush(2);
    do_read(32'h020, 32'hAAAA_0001, 1'b1);
    do_read(32'h0A4, 32'hBBBB_0005, 1'b1);

    // Read+write together acts as a store and dirties the line
    do_store(32'h024, 32'hCAFE_0044, 1'b1);
    do_read(32'h024, 32'hCAFE_0044, 1'b1);
    mem_q.push_back(mk(1'b1, 32'h020, 32'hAAAA_0001, 32'hCAFE_0044, 32'h0, 1'b0));
    do_flush(1);

    // Reset three cycles into a refill
    mem_q.push_back(mk(1'b0, 32'hC00, 32'h0, 32'h0, 32'h0, 1'b1));
    @(posedge clk); #1;
    addr = 32'hC00; rd = 1; wr = 0;
    n = 0;
    @(negedge clk);
    while (!mem_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_en) fail_now("refill_start_timeout");
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst_stall", {31'b0, stall}, 32'd0);
    check("midrst_data", rdata, 32'd0);
    check("midrst_mem_en", {31'b0, mem_en}, 32'd0);
    check("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_mem_data", {31'b0, (mem_wdata != '0)}, 32'd0);
    rd = 0;
    @(posedge clk); #3;
    rst_n = 1;
    mem_q.push_back(mk(1'b0, 32'hC00, 32'h0, 32'h0, 32'h0C00_0000, 1'b0));
    do_read(32'hC00, 32'h0C00_0000, 1'b0);

    repeat (5) @(posedge clk);
    check("mem_queue_drained", mem_q.size(), 32'd0);
    check("cpu_queue_drained", cpu_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
